// File: rtl/freelist_cp_pkg.sv
// Shared types and default sizes for the free-list checkpoint controller.
package freelist_cp_pkg;
    localparam int NUM_CP = 8;
    localparam int CP_LOG = 3;
    localparam int FL_LOG = 7;

    typedef enum logic {NORMAL, RECOVER} cp_state_t;

    typedef struct packed {
        logic              valid;
        logic              resolved;
        logic [FL_LOG-1:0] head;
    } cp_entry_t;
endpackage

// File: rtl/cp_younger_mask.sv
// Marks every slot younger than checkpoint cp_id (cp_id+1 .. tail_ptr-1, circular).
module cp_younger_mask #(
    parameter int NUM_CP = 8,
    parameter int CP_LOG = 3
) (
    input  logic [CP_LOG-1:0] head_ptr,
    input  logic [CP_LOG-1:0] tail_ptr,
    input  logic [CP_LOG-1:0] cp_id,
    output logic [NUM_CP-1:0] mask
);
    logic [CP_LOG-1:0] off_x;
    logic [CP_LOG-1:0] span;

    assign off_x = cp_id - head_ptr;
    // span is 0..NUM_CP-1; a full table (tail==head) still yields the right count
    assign span  = tail_ptr - cp_id - CP_LOG'(1);

    for (genvar i = 0; i < NUM_CP; i++) begin : g_slot
        logic [CP_LOG-1:0] off_i;
        logic [CP_LOG-1:0] dist_i;
        assign off_i   = CP_LOG'(i) - head_ptr;
        assign dist_i  = CP_LOG'(i) - cp_id;
        assign mask[i] = (off_i > off_x) && (dist_i <= span);
    end
endmodule

// File: rtl/freelist_checkpoint_ctrl.sv
// Branch checkpoint table for the speculative free list: allocate, verify/retire, mispredict restore.
// CP_RECOVER_BYPASS_EN: drive restored head and recovery flag combinationally in the mispredict cycle.
module freelist_checkpoint_ctrl #(
    parameter int NUM_CP = freelist_cp_pkg::NUM_CP,
    parameter int CP_LOG = freelist_cp_pkg::CP_LOG,
    parameter int FL_LOG = freelist_cp_pkg::FL_LOG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              recoverFlag_i,
    input  logic              stall_i,
    input  logic              cpAlloc_i,
    input  logic [FL_LOG-1:0] freeListHead_i,
    output logic              cpAllocAck_o,
    output logic [CP_LOG-1:0] cpId_o,
    output logic              cpFull_o,
    input  logic              ctrlVerified_i,
    input  logic              ctrlMispredict_i,
    input  logic [CP_LOG-1:0] ctrlCpId_i,
    output logic [FL_LOG-1:0] freeListHeadCp_o,
    output logic              flagRecoverEX_o,
    output logic [CP_LOG:0]   cpCount_o
);
    import freelist_cp_pkg::*;

    cp_entry_t [NUM_CP-1:0] slots_q;
    logic [CP_LOG-1:0]      head_ptr_q, tail_ptr_q;
    logic [CP_LOG:0]        count_q;
    cp_state_t              state_q, state_d;
    logic [FL_LOG-1:0]      head_cp_q;
    logic                   flag_q;
    logic [NUM_CP-1:0]      younger;
    logic [CP_LOG-1:0]      mp_dist;
    logic mp_valid, vf_hit, retire, alloc_blocked, ack;

    cp_younger_mask #(.NUM_CP(NUM_CP), .CP_LOG(CP_LOG)) u_mask (
        .head_ptr(head_ptr_q),
        .tail_ptr(tail_ptr_q),
        .cp_id   (ctrlCpId_i),
        .mask    (younger)
    );

    assign cpFull_o = (count_q == (CP_LOG+1)'(NUM_CP));
    assign mp_valid = ctrlVerified_i & ctrlMispredict_i & slots_q[ctrlCpId_i].valid & !recoverFlag_i;
    assign vf_hit   = ctrlVerified_i & !ctrlMispredict_i & slots_q[ctrlCpId_i].valid
                      & !slots_q[ctrlCpId_i].resolved;
    // A mispredict freezes retirement except when the mispredicted slot itself is the head
    assign retire   = slots_q[head_ptr_q].valid & slots_q[head_ptr_q].resolved
                      & (!mp_valid | (ctrlCpId_i == head_ptr_q));
    assign mp_dist  = ctrlCpId_i - head_ptr_q;
    assign ack      = cpAlloc_i & !stall_i & !cpFull_o & !alloc_blocked & !mp_valid
                      & !recoverFlag_i & !reset;

    assign cpAllocAck_o = ack;
    assign cpId_o       = tail_ptr_q;
    assign cpCount_o    = count_q;

`ifdef CP_RECOVER_BYPASS_EN
    assign freeListHeadCp_o = mp_valid ? slots_q[ctrlCpId_i].head : head_cp_q;
    assign flagRecoverEX_o  = mp_valid;
`else
    assign freeListHeadCp_o = head_cp_q;
    assign flagRecoverEX_o  = flag_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= NORMAL;
        else if (recoverFlag_i) state_q <= NORMAL;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = NORMAL;
        if (mp_valid) state_d = RECOVER;
    end

    always_comb begin
        alloc_blocked = (state_q == RECOVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slots_q    <= '0;
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
            count_q    <= '0;
            head_cp_q  <= '0;
            flag_q     <= 1'b0;
        end else if (recoverFlag_i) begin
            slots_q    <= '0;
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
            count_q    <= '0;
            head_cp_q  <= '0;
            flag_q     <= 1'b0;
        end else begin
            if (mp_valid) begin
                for (int i = 0; i < NUM_CP; i++) begin
                    if (younger[i]) begin
                        slots_q[i].valid    <= 1'b0;
                        slots_q[i].resolved <= 1'b0;
                    end
                end
                slots_q[ctrlCpId_i].resolved <= 1'b1;
                tail_ptr_q <= ctrlCpId_i + CP_LOG'(1);
                count_q    <= {1'b0, mp_dist} + (CP_LOG+1)'(1) - (CP_LOG+1)'(retire);
                head_cp_q  <= slots_q[ctrlCpId_i].head;
                flag_q     <= 1'b1;
            end else begin
                flag_q <= 1'b0;
                if (vf_hit) slots_q[ctrlCpId_i].resolved <= 1'b1;
                if (ack) begin
                    slots_q[tail_ptr_q].valid    <= 1'b1;
                    slots_q[tail_ptr_q].resolved <= 1'b0;
                    slots_q[tail_ptr_q].head     <= freeListHead_i;
                    tail_ptr_q <= tail_ptr_q + CP_LOG'(1);
                end
                count_q <= count_q + (CP_LOG+1)'(ack) - (CP_LOG+1)'(retire);
            end
            // Placed last so retiring the mispredicted head slot wins over setting resolved
            if (retire) begin
                slots_q[head_ptr_q].valid    <= 1'b0;
                slots_q[head_ptr_q].resolved <= 1'b0;
                head_ptr_q <= head_ptr_q + CP_LOG'(1);
            end
        end
    end
endmodule

// File: tb/tb_freelist_checkpoint_ctrl.sv
// Directed bench for freelist_checkpoint_ctrl: reset, fill, in-order retire, wrap mispredict, recovery.
module tb_freelist_checkpoint_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       recoverFlag_i, stall_i, cpAlloc_i;
    logic [6:0] freeListHead_i;
    logic       cpAllocAck_o;
    logic [2:0] cpId_o;
    logic       cpFull_o;
    logic       ctrlVerified_i, ctrlMispredict_i;
    logic [2:0] ctrlCpId_i;
    logic [6:0] freeListHeadCp_o;
    logic       flagRecoverEX_o;
    logic [3:0] cpCount_o;

    int checks = 0;
    int failures = 0;

    freelist_checkpoint_ctrl #(.NUM_CP(8), .CP_LOG(3), .FL_LOG(7)) dut (
        .clk             (clk),
        .reset           (reset),
        .recoverFlag_i   (recoverFlag_i),
        .stall_i         (stall_i),
        .cpAlloc_i       (cpAlloc_i),
        .freeListHead_i  (freeListHead_i),
        .cpAllocAck_o    (cpAllocAck_o),
        .cpId_o          (cpId_o),
        .cpFull_o        (cpFull_o),
        .ctrlVerified_i  (ctrlVerified_i),
        .ctrlMispredict_i(ctrlMispredict_i),
        .ctrlCpId_i      (ctrlCpId_i),
        .freeListHeadCp_o(freeListHeadCp_o),
        .flagRecoverEX_o (flagRecoverEX_o),
        .cpCount_o       (cpCount_o)
    );

    always #5 clk = ~clk;

    // Occupancy bound holds on every cycle
    always @(negedge clk) begin
        checks++;
        if (cpCount_o > 4'd8) begin
            failures++;
            $display("FAIL count_bound got=%0d max=8", cpCount_o);
        end
    end

    task automatic idle_inputs();
        recoverFlag_i = 0; stall_i = 0; cpAlloc_i = 0; freeListHead_i = '0;
        ctrlVerified_i = 0; ctrlMispredict_i = 0; ctrlCpId_i = '0;
    endtask

    // All step tasks start and end just after a falling edge
    task automatic apply_reset();
        idle_inputs();
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic step_alloc(input logic [6:0] h, output logic ack, output logic [2:0] id);
        cpAlloc_i = 1; freeListHead_i = h;
        #1;
        ack = cpAllocAck_o; id = cpId_o;
        @(negedge clk);
        cpAlloc_i = 0;
    endtask

    task automatic step_verify(input logic [2:0] id, input logic mp);
        ctrlVerified_i = 1; ctrlMispredict_i = mp; ctrlCpId_i = id;
        @(negedge clk);
        ctrlVerified_i = 0; ctrlMispredict_i = 0;
    endtask

    task automatic test_reset();
        logic ack; logic [2:0] id;
        checks++; if (cpCount_o !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", cpCount_o); end
        checks++; if (flagRecoverEX_o !== 1'b0) begin failures++; $display("FAIL rst_flag got=%b exp=0", flagRecoverEX_o); end
        checks++; if (cpFull_o !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", cpFull_o); end
        checks++; if (freeListHeadCp_o !== 7'd0) begin failures++; $display("FAIL rst_headcp got=%0d exp=0", freeListHeadCp_o); end
        cpAlloc_i = 1; #1;
        checks++; if (cpAllocAck_o !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", cpAllocAck_o); end
        @(negedge clk);
        apply_reset();
        for (int i = 0; i < 5; i++) step_alloc(7'(i + 1), ack, id);
        checks++; if (cpCount_o !== 4'd5) begin failures++; $display("FAIL pre_rst_count got=%0d exp=5", cpCount_o); end
        #2 reset = 1;
        #1;
        checks++; if (cpCount_o !== 4'd0) begin failures++; $display("FAIL mid_rst_count got=%0d exp=0", cpCount_o); end
        checks++; if (flagRecoverEX_o !== 1'b0) begin failures++; $display("FAIL mid_rst_flag got=%b exp=0", flagRecoverEX_o); end
        checks++; if (cpFull_o !== 1'b0) begin failures++; $display("FAIL mid_rst_full got=%b exp=0", cpFull_o); end
        @(negedge clk);
        reset = 0;
        step_alloc(7'd9, ack, id);
        checks++; if (ack !== 1'b1 || id !== 3'd0) begin failures++; $display("FAIL post_rst_alloc got ack=%b id=%0d exp ack=1 id=0", ack, id); end
    endtask

    task automatic test_full();
        logic ack; logic [2:0] id;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            step_alloc(7'(10 + i), ack, id);
            checks++;
            if (ack !== 1'b1 || id !== 3'(i)) begin
                failures++; $display("FAIL fill_alloc%0d got ack=%b id=%0d exp ack=1 id=%0d", i, ack, id, i);
            end
        end
        checks++; if (cpFull_o !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", cpFull_o); end
        checks++; if (cpCount_o !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", cpCount_o); end
        step_alloc(7'd18, ack, id);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL ninth_ack got=%b exp=0", ack); end
        checks++; if (cpCount_o !== 4'd8) begin failures++; $display("FAIL ninth_count got=%0d exp=8", cpCount_o); end
    endtask

    task automatic test_retire_order();
        logic ack; logic [2:0] id;
        logic [3:0] exp_cnt [6];
        exp_cnt = '{4'd4, 4'd4, 4'd3, 4'd2, 4'd1, 4'd1};
        apply_reset();
        for (int i = 0; i < 4; i++) step_alloc(7'(30 + i), ack, id);
        step_verify(3'd2, 1'b0);
        checks++; if (cpCount_o !== exp_cnt[0]) begin failures++; $display("FAIL ret_c0 got=%0d exp=%0d", cpCount_o, exp_cnt[0]); end
        step_verify(3'd0, 1'b0);
        checks++; if (cpCount_o !== exp_cnt[1]) begin failures++; $display("FAIL ret_c1 got=%0d exp=%0d", cpCount_o, exp_cnt[1]); end
        step_verify(3'd1, 1'b0);
        checks++; if (cpCount_o !== exp_cnt[2]) begin failures++; $display("FAIL ret_c2 got=%0d exp=%0d", cpCount_o, exp_cnt[2]); end
        for (int k = 3; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (cpCount_o !== exp_cnt[k]) begin failures++; $display("FAIL ret_c%0d got=%0d exp=%0d", k, cpCount_o, exp_cnt[k]); end
        end
        step_alloc(7'd50, ack, id);
        checks++; if (ack !== 1'b1 || id !== 3'd4) begin failures++; $display("FAIL ret_next_alloc got ack=%b id=%0d exp ack=1 id=4", ack, id); end
    endtask

    task automatic test_wrap_mispredict();
        logic ack; logic [2:0] id;
        apply_reset();
        for (int i = 0; i < 6; i++) step_alloc(7'(i), ack, id);
        for (int i = 0; i < 6; i++) step_verify(3'(i), 1'b0);
        @(negedge clk);
        checks++; if (cpCount_o !== 4'd0) begin failures++; $display("FAIL wrap_drain got=%0d exp=0", cpCount_o); end
        for (int i = 0; i < 4; i++) begin
            step_alloc(7'(40 + i), ack, id);
            checks++;
            if (ack !== 1'b1 || id !== 3'((6 + i) % 8)) begin
                failures++; $display("FAIL wrap_alloc%0d got ack=%b id=%0d exp ack=1 id=%0d", i, ack, id, (6 + i) % 8);
            end
        end
        step_verify(3'd7, 1'b1);
        checks++; if (freeListHeadCp_o !== 7'd41) begin failures++; $display("FAIL wrap_headcp got=%0d exp=41", freeListHeadCp_o); end
        checks++; if (flagRecoverEX_o !== 1'b1) begin failures++; $display("FAIL wrap_flag got=%b exp=1", flagRecoverEX_o); end
        checks++; if (cpCount_o !== 4'd2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", cpCount_o); end
        checks++; if (cpId_o !== 3'd0) begin failures++; $display("FAIL wrap_tail got=%0d exp=0", cpId_o); end
        @(negedge clk);
        checks++; if (flagRecoverEX_o !== 1'b0) begin failures++; $display("FAIL wrap_flag_drop got=%b exp=0", flagRecoverEX_o); end
        checks++; if (freeListHeadCp_o !== 7'd41) begin failures++; $display("FAIL wrap_headcp_hold got=%0d exp=41", freeListHeadCp_o); end
        step_alloc(7'd44, ack, id);
        checks++; if (ack !== 1'b1 || id !== 3'd0) begin failures++; $display("FAIL wrap_realloc got ack=%b id=%0d exp ack=1 id=0", ack, id); end
    endtask

    task automatic test_mispredict_alloc();
        logic ack; logic [2:0] id;
        apply_reset();
        for (int i = 0; i < 5; i++) step_alloc(7'(20 + i), ack, id);
        cpAlloc_i = 1; freeListHead_i = 7'd60;
        ctrlVerified_i = 1; ctrlMispredict_i = 1; ctrlCpId_i = 3'd2;
        #1;
        checks++; if (cpAllocAck_o !== 1'b0) begin failures++; $display("FAIL mpa_ack_same got=%b exp=0", cpAllocAck_o); end
        @(negedge clk);
        ctrlVerified_i = 0; ctrlMispredict_i = 0;
        #1;
        checks++; if (cpAllocAck_o !== 1'b0) begin failures++; $display("FAIL mpa_ack_recover got=%b exp=0", cpAllocAck_o); end
        checks++; if (flagRecoverEX_o !== 1'b1) begin failures++; $display("FAIL mpa_flag got=%b exp=1", flagRecoverEX_o); end
        checks++; if (freeListHeadCp_o !== 7'd22) begin failures++; $display("FAIL mpa_headcp got=%0d exp=22", freeListHeadCp_o); end
        checks++; if (cpCount_o !== 4'd3) begin failures++; $display("FAIL mpa_count got=%0d exp=3", cpCount_o); end
        @(negedge clk);
        #1;
        checks++; if (cpAllocAck_o !== 1'b1 || cpId_o !== 3'd3) begin failures++; $display("FAIL mpa_grant got ack=%b id=%0d exp ack=1 id=3", cpAllocAck_o, cpId_o); end
        @(negedge clk);
        cpAlloc_i = 0;
        checks++; if (cpCount_o !== 4'd4) begin failures++; $display("FAIL mpa_count2 got=%0d exp=4", cpCount_o); end
        step_verify(3'd4, 1'b1);
        checks++; if (flagRecoverEX_o !== 1'b0) begin failures++; $display("FAIL mpa_stale_flag got=%b exp=0", flagRecoverEX_o); end
        checks++; if (cpCount_o !== 4'd4) begin failures++; $display("FAIL mpa_stale_count got=%0d exp=4", cpCount_o); end
    endtask

    task automatic test_recover_flag();
        logic ack; logic [2:0] id;
        recoverFlag_i = 1;
        ctrlVerified_i = 1; ctrlMispredict_i = 1; ctrlCpId_i = 3'd1;
        @(negedge clk);
        recoverFlag_i = 0; ctrlVerified_i = 0; ctrlMispredict_i = 0;
        checks++; if (cpCount_o !== 4'd0) begin failures++; $display("FAIL rf_count got=%0d exp=0", cpCount_o); end
        checks++; if (flagRecoverEX_o !== 1'b0) begin failures++; $display("FAIL rf_flag got=%b exp=0", flagRecoverEX_o); end
        checks++; if (freeListHeadCp_o !== 7'd0) begin failures++; $display("FAIL rf_headcp got=%0d exp=0", freeListHeadCp_o); end
        @(negedge clk);
        checks++; if (flagRecoverEX_o !== 1'b0) begin failures++; $display("FAIL rf_flag_later got=%b exp=0", flagRecoverEX_o); end
        step_alloc(7'd70, ack, id);
        checks++; if (ack !== 1'b1 || id !== 3'd0) begin failures++; $display("FAIL rf_alloc got ack=%b id=%0d exp ack=1 id=0", ack, id); end
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_full();
        test_retire_order();
        test_wrap_mispredict();
        test_mispredict_alloc();
        test_recover_flag();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/freelist_checkpoint_ctrl.md
Name: freelist_checkpoint_ctrl

Overview:
- Manages the branch-checkpoint table for the speculative free list.
- Records the free-list head at each control-instruction rename and retires checkpoints once they are verified.
- On a mispredict, drives the restored head (freeListHeadCp) and the recovery flag into the free list and discards younger checkpoints.
- Sits between rename/dispatch (allocation) and the execute-stage branch resolution.

Parameters:
NUM_CP, 8, number of checkpoint slots; must be a power of two
CP_LOG, 3, log2(NUM_CP)
FL_LOG, 7, free-list head pointer width (SIZE_FREE_LIST_LOG)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
recoverFlag_i  in  1  full pipeline flush
stall_i  in  1  rename stall; blocks allocation
cpAlloc_i  in  1  request one checkpoint this cycle
freeListHead_i  in  FL_LOG  free-list head value to record
cpAllocAck_o  out  1  allocation accepted this cycle
cpId_o  out  CP_LOG  slot id granted (valid with ack)
cpFull_o  out  1  no free slot
ctrlVerified_i  in  1  branch resolved
ctrlMispredict_i  in  1  resolved branch mispredicted (qualified by ctrlVerified_i)
ctrlCpId_i  in  CP_LOG  slot of the resolved branch
freeListHeadCp_o  out  FL_LOG  restored head for the free list
flagRecoverEX_o  out  1  one-cycle recovery pulse to the free list
cpCount_o  out  CP_LOG+1  occupied slots

Behaviour:
- State per slot: valid, resolved, head[FL_LOG-1:0]. Pointers headPtr/tailPtr wrap modulo NUM_CP; count is CP_LOG+1 bits.
- Reset (async) and recoverFlag_i (synchronous) both clear:
  - all valid/resolved bits; headPtr=tailPtr=0; count=0; state=NORMAL.
  - Outputs go to 0: flagRecoverEX_o, freeListHeadCp_o, cpAllocAck_o, cpCount_o.
- cpFull_o = (count==NUM_CP), combinational.
- cpAllocAck_o is combinational and is 1 only when all of these hold: cpAlloc_i, !stall_i, !cpFull_o, state==NORMAL, no mispredict this cycle, !recoverFlag_i.
- On ack:
  - cpId_o = tailPtr.
  - Next edge: slot[tailPtr] = {valid=1, resolved=0, head=freeListHead_i}; tailPtr++.
- Verify (ctrlVerified_i & !ctrlMispredict_i) on a valid, unresolved slot sets resolved. Verify on an invalid or already-resolved slot is ignored.
- Retire: each cycle, if slot[headPtr] is valid and resolved, clear it and increment headPtr. At most one retire per cycle. Retire and alloc in the same cycle leave count unchanged.
- Mispredict (ctrlVerified_i & ctrlMispredict_i) on valid slot X:
  - Slot X becomes resolved.
  - All slots younger than X (X+1 .. tailPtr-1, modulo) are invalidated.
  - tailPtr = X+1 mod NUM_CP; count = ((X-headPtr) mod NUM_CP)+1, minus 1 if X retires this same cycle.
  - freeListHeadCp_o <= slot[X].head; flagRecoverEX_o <= 1 on the next edge.
  - FSM NORMAL->RECOVER. RECOVER lasts exactly one cycle (flagRecoverEX_o=1, alloc blocked), then returns to NORMAL.
  - Mispredict on an invalid slot is ignored.
- Priority: recoverFlag_i > mispredict > verify/retire > alloc. Mispredict and alloc in the same cycle: alloc is dropped (ack=0).
- A second mispredict during RECOVER is processed normally on an older valid slot; on an already-invalidated slot it is ignored.
- freeListHeadCp_o holds its last value outside recovery.
- count never exceeds NUM_CP and never underflows; the bench asserts this.

Optional Feature:
- Macro CP_RECOVER_BYPASS_EN.
- Defined: freeListHeadCp_o = slot[ctrlCpId_i].head and flagRecoverEX_o = valid mispredict, both combinational in the mispredict cycle (0-cycle latency). RECOVER state still blocks alloc for one cycle.
- Undefined: registered outputs, 1-cycle latency as above.

Decomposition:
- Package freelist_cp_pkg holds:
  - NUM_CP, CP_LOG, FL_LOG defaults
  - cp_state_t enum {NORMAL, RECOVER}
  - cp_entry_t struct {valid, resolved, head}
- One sub-module, cp_younger_mask: combinational; inputs headPtr, tailPtr, X; outputs the NUM_CP-bit mask of slots younger than X, handling wrap.

Test Plan:
- Reset mid-run with 5 slots occupied -> same cycle: cpCount_o=0, flagRecoverEX_o=0, cpFull_o=0; first alloc after reset returns cpId_o=0.
- 8 allocs with heads 10..17, no verify -> cpFull_o=1 and cpCount_o=8; 9th alloc gets ack=0 and the count stays 8.
- Alloc ids 0..3; verify 2, then 0, then 1 -> retirement is in order: 0 retires, then 1, then 2 on successive cycles; count goes 4,3,2,1. Slot 3 remains.
- Wrap case: headPtr=6, ids 6,7,0,1 valid with heads 40,41,42,43; mispredict id 7 -> next cycle freeListHeadCp_o=41 and flagRecoverEX_o=1 for one cycle; tailPtr=0, count=2; next alloc returns id 0.
- Mispredict id 2 and alloc in the same cycle -> ack=0. The following cycle (RECOVER) alloc is also refused. The alloc after that is granted id 3.
- recoverFlag_i asserted together with mispredict -> table cleared; flagRecoverEX_o stays 0.
